// File: rtl/fetch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_redirect_ctrl
//
// Purpose:
//   Resolves branches / JAL / JALR sitting in EX and drives the fetch stage's
//   next-PC selection (branch_taken, branch_addr, pc_write) together with the
//   IF/ID and ID/EX hold/flush controls. A redirect that resolves while the
//   front end is frozen by ext_stall is latched and issued exactly once, in
//   the first cycle after the stall releases.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   ex_valid, ex_is_branch,
//   ex_is_jal, ex_is_jalr       EX instruction qualifiers
//   ex_funct3                   branch condition code
//   ex_rs1, ex_rs2              forwarded operands
//   ex_pc, ex_imm               EX PC and sign-extended immediate
//   load_use_stall              one-cycle front-end hold request
//   ext_stall                   whole front end frozen
//   branch_taken, branch_addr   next-PC select and redirect target to fetch
//   pc_write                    PC register enable
//   if_id_write                 IF/ID register enable
//   if_id_flush, id_ex_flush    pipeline flush controls
//   redirect_pending            a latched redirect awaits issue
//
// Optional feature (macro BRANCH_STATS_EN):
//   Adds saturating statistics counters stat_branches, stat_taken and
//   stat_stall_cyc (CNT_W bits each). Without the macro they are absent.
// ---------------------------------------------------------------------------
module fetch_redirect_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic            load_use_stall,
    input  logic            ext_stall,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_addr,
    output logic            pc_write,
    output logic            if_id_write,
    output logic            if_id_flush,
    output logic            id_ex_flush,
    output logic            redirect_pending
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_taken,
    output logic [CNT_W-1:0] stat_stall_cyc
`endif
);

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t          state_reg;
    logic [XLEN-1:0] pend_addr_reg;

    // ------------------------------------------------------------------
    // Branch condition and redirect target (purely combinational)
    // ------------------------------------------------------------------
    logic            eq;
    logic            lt_s;
    logic            lt_u;
    logic            cond;
    logic            take;
    logic [XLEN-1:0] seq_addr;
    logic [XLEN-1:0] pc_rel_target;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;

    assign eq   = (ex_rs1 == ex_rs2);
    assign lt_s = ($signed(ex_rs1) < $signed(ex_rs2));
    assign lt_u = (ex_rs1 < ex_rs2);

    always_comb begin
        cond = 1'b0;
        case (ex_funct3)
            3'b000:  cond = eq;
            3'b001:  cond = ~eq;
            3'b100:  cond = lt_s;
            3'b101:  cond = ~lt_s;
            3'b110:  cond = lt_u;
            3'b111:  cond = ~lt_u;
            default: cond = 1'b0;
        endcase
    end

    assign take = ex_valid & (ex_is_jal | ex_is_jalr | (ex_is_branch & cond));

    assign seq_addr      = ex_pc + XLEN'(4);
    assign pc_rel_target = ex_pc + ex_imm;
    assign jalr_sum      = ex_rs1 + ex_imm;

    // JALR wins over JAL/branch when several flags are set; JAL and branch
    // share the PC-relative target, so only JALR needs distinguishing.
    assign target = ex_is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : pc_rel_target;

    // ------------------------------------------------------------------
    // Output decode. Outputs must react in the same cycle the branch
    // resolves, so they are decoded from the state register and inputs.
    // ------------------------------------------------------------------
    always_comb begin
        branch_taken     = 1'b0;
        branch_addr      = seq_addr;
        pc_write         = 1'b0;
        if_id_write      = 1'b0;
        if_id_flush      = 1'b0;
        id_ex_flush      = 1'b0;
        redirect_pending = 1'b0;

        if (reset) begin
            branch_addr = '0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            case (state_reg)
                RUN: begin
                    if (take && !ext_stall) begin
                        // Redirect overrides load_use_stall: the held
                        // instruction is on the wrong path anyway.
                        branch_taken = 1'b1;
                        branch_addr  = target;
                        pc_write     = 1'b1;
                        if_id_write  = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                    end else if (take) begin
                        // Frozen: hold everything, target is latched below.
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                    end else begin
                        pc_write    = ~(load_use_stall | ext_stall);
                        if_id_write = ~(load_use_stall | ext_stall);
                        id_ex_flush = load_use_stall & ~ext_stall;
                    end
                end
                PEND: begin
                    redirect_pending = 1'b1;
                    if (!ext_stall) begin
                        branch_taken = 1'b1;
                        branch_addr  = pend_addr_reg;
                        pc_write     = 1'b1;
                        if_id_write  = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State: EX inputs are ignored in PEND so the frozen instruction is
    // never resolved a second time.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= RUN;
            pend_addr_reg <= '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (take && ext_stall) begin
                        state_reg     <= PEND;
                        pend_addr_reg <= target;
                    end
                end
                PEND: begin
                    if (!ext_stall) begin
                        state_reg <= RUN;
                    end
                end
                default: state_reg <= RUN;
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    // ------------------------------------------------------------------
    // Saturating statistics counters
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] stat_branches_reg;
    logic [CNT_W-1:0] stat_taken_reg;
    logic [CNT_W-1:0] stat_stall_cyc_reg;
    logic             resolved;

    // Counted only in RUN, so a redirect that goes through PEND is seen once.
    assign resolved = (state_reg == RUN) & ex_valid &
                      (ex_is_branch | ex_is_jal | ex_is_jalr);

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches_reg  <= '0;
            stat_taken_reg     <= '0;
            stat_stall_cyc_reg <= '0;
        end else begin
            if (resolved && !(&stat_branches_reg))
                stat_branches_reg <= stat_branches_reg + CNT_W'(1);
            if (branch_taken && !(&stat_taken_reg))
                stat_taken_reg <= stat_taken_reg + CNT_W'(1);
            if (!pc_write && !(&stat_stall_cyc_reg))
                stat_stall_cyc_reg <= stat_stall_cyc_reg + CNT_W'(1);
        end
    end

    assign stat_branches  = stat_branches_reg;
    assign stat_taken     = stat_taken_reg;
    assign stat_stall_cyc = stat_stall_cyc_reg;
`endif

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
- Control-side counterpart of the fetch stage: resolves branches/jumps in EX and drives the fetch stage's `branch_taken`, `branch_addr` and `pc_write` inputs.
- Also generates pipeline flush/hold controls.
- Holds a redirect pending while the front end is frozen by an external stall, and issues it exactly once when the stall releases.

Parameters:
- XLEN, 32, datapath/address width.
- CNT_W, 32, width of statistics counters (used only with BRANCH_STATS_EN).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all state on the rising edge where it is high.
- ex_valid  input  1  EX stage holds a real (non-bubble) instruction.
- ex_is_branch  input  1  EX instruction is a conditional branch.
- ex_is_jal  input  1  EX instruction is JAL.
- ex_is_jalr  input  1  EX instruction is JALR.
- ex_funct3  input  3  branch condition code.
- ex_rs1  input  XLEN  forwarded rs1 value.
- ex_rs2  input  XLEN  forwarded rs2 value.
- ex_pc  input  XLEN  PC of EX instruction.
- ex_imm  input  XLEN  sign-extended immediate.
- load_use_stall  input  1  hazard unit requests a one-cycle front-end hold.
- ext_stall  input  1  whole front end frozen (e.g. memory wait).
- branch_taken  output  1  to fetch: select `branch_addr` as next PC.
- branch_addr  output  XLEN  redirect target.
- pc_write  output  1  to fetch: PC register update enable.
- if_id_write  output  1  IF/ID register enable.
- if_id_flush  output  1  zero IF/ID this edge.
- id_ex_flush  output  1  insert bubble into ID/EX this edge.
- redirect_pending  output  1  a latched redirect awaits issue.

Behaviour:
- Resolution (combinational):
  - `cond` = BEQ(000) eq, BNE(001) ne, BLT(100) signed lt, BGE(101) signed ge, BLTU(110) unsigned lt, BGEU(111) unsigned ge; funct3 010/011 give cond=0.
  - `take` = ex_valid & (ex_is_jal | ex_is_jalr | (ex_is_branch & cond)).
  - If two or more `is_*` flags are set, priority is jalr > jal > branch.
- Target arithmetic:
  - Branch/JAL: ex_pc+ex_imm, modulo 2^XLEN.
  - JALR: (ex_rs1+ex_imm) with bit0 cleared; wrap-around ignored.
- FSM states:
  - RUN
    - take & ~ext_stall: issue redirect this cycle.
      - branch_taken=1, branch_addr=target, pc_write=1, if_id_flush=1, id_ex_flush=1, if_id_write=1.
      - Stay in RUN.
      - Redirect overrides load_use_stall: the stalled instruction is wrong-path.
    - take & ext_stall: latch target into `pend_addr`, go to PEND. Outputs this cycle: pc_write=0, if_id_write=0, branch_taken=0, no flush.
    - ~take: branch_taken=0, pc_write=if_id_write=~(load_use_stall|ext_stall).
      - id_ex_flush=load_use_stall & ~ext_stall.
      - if_id_flush=0.
  - PEND
    - EX inputs ignored, so the held instruction is never re-resolved.
    - redirect_pending=1.
    - While ext_stall=1: pc_write=0, if_id_write=0, no flush.
    - First cycle ext_stall=0: branch_taken=1, branch_addr=pend_addr, pc_write=1, both flushes=1; go to RUN.
    - Any load_use_stall in that cycle is ignored.
- branch_addr: when branch_taken=0, it equals ex_pc+4 (don't-care to fetch, fixed for waveform determinism).
- Reset (any state, including mid-PEND):
  - State=RUN, pend_addr=0, pending redirect discarded.
  - While reset is high the outputs are forced: branch_taken=0, branch_addr=0, pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, redirect_pending=0.
  - Counters cleared.
- Latency:
  - Unstalled redirect: zero cycles (same cycle as resolution).
  - Stalled redirect: issued in the first cycle after ext_stall deasserts.

Optional Feature:
- Macro BRANCH_STATS_EN.
- When defined:
  - Adds outputs stat_branches, stat_taken, stat_stall_cyc, each CNT_W wide.
  - stat_branches increments on each resolved control-flow instruction in RUN (ex_valid & any is_* flag), counted once even if it goes to PEND.
  - stat_taken increments on each redirect issue.
  - stat_stall_cyc increments each cycle pc_write=0 and reset=0.
  - All counters saturate at all-ones and are cleared by reset.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- BEQ, rs1=rs2=5, ex_pc=0x100, imm=0x20, no stalls -> same cycle: branch_taken=1, branch_addr=0x120, both flushes=1, pc_write=1.
- BLT rs1=0xFFFFFFFF, rs2=1 -> taken. BLTU with the same operands -> not taken; branch_addr=ex_pc+4, pc_write=1.
- JALR rs1=0x203, imm=4 while load_use_stall=1 -> branch_addr=0x206, pc_write=1 (redirect overrides stall).
- JAL ex_pc=0x40, imm=0x100 with ext_stall=1 for 3 cycles:
  - PEND entered; redirect_pending=1, pc_write=0 during the stall.
  - Cycle 4 (stall low): branch_taken=1, addr=0x140.
  - Next cycle: RUN, no second redirect.
- Reset asserted in the 2nd cycle of PEND:
  - Next cycle: RUN, redirect_pending=0, branch_taken=0.
  - After reset drops with no take: pc_write=1.
- With BRANCH_STATS_EN:
  - 3 branches (2 taken) plus one 2-cycle ext_stall -> stat_branches=3, stat_taken=2, stat_stall_cyc=2.
  - Preloaded all-ones counter stays all-ones.
